// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the multi-channel AES-CBC scheduler.
package aes_sched_pkg;

    localparam int DW = 128;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_e;

    // Channel index width; a single channel still needs one bit of index.
    function automatic int chIdxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter
    import aes_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = chIdxWidth(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CW-1:0]  idx_o,
    output logic           any_o
);

    always_comb begin
        int cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = 0; i < NCH; i++) begin
            cand = (int'(ptr_i) + i) % NCH;
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = CW'(cand);
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_cbc_scheduler.sv
// Shares one encrypt and one decrypt AES core among NCH CBC streams,
// keeping per-channel chaining context and returning tagged results.
module aes_cbc_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = aes_sched_pkg::DW
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NCH-1:0]                 ch_start,
    input  logic [NCH-1:0]                 ch_mode,
    input  logic [NCH*DW-1:0]              ch_iv,
    input  logic [NCH-1:0]                 ch_valid,
    input  logic [NCH*DW-1:0]              ch_data,
    output logic [NCH-1:0]                 ch_ready,
    output logic                           out_valid,
    output logic [DW-1:0]                  out_data,
    output logic [chIdxWidth(NCH)-1:0]     out_ch,
    input  logic                           out_ready,
    output logic [DW-1:0]                  core_enc_in,
    input  logic [DW-1:0]                  core_enc_out,
    output logic [DW-1:0]                  core_dec_in,
    input  logic [DW-1:0]                  core_dec_out,
    output logic [31:0]                    blk_count
);

    localparam int CW = chIdxWidth(NCH);

    state_e         state_q, state_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]  in_q, in_d;
    logic [CW-1:0]  g_q, g_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]  out_ch_q, out_ch_d;
    logic [31:0]    blk_count_q, blk_count_d;

    logic [DW-1:0]  chain_q [NCH];
    logic [NCH-1:0] mode_q;
    logic [NCH-1:0] active_q;

    logic [NCH-1:0] req, gnt;
    logic [CW-1:0]  gnt_idx;
    logic           gnt_any;
    logic           accept;
    logic           deliver;
    logic [DW-1:0]  cur_chain;
    logic           cur_enc;
    logic [DW-1:0]  result;
    logic [DW-1:0]  new_chain;

    // A channel being (re)started this cycle is held off so its new IV applies first.
    assign req = active_q & ch_valid & ~ch_start;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign accept  = (state_q == IDLE) && gnt_any;
    assign deliver = (state_q == OUT) && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the core for the current direction sees data; the other is held at zero.
    always_comb begin
        ch_ready    = '0;
        out_valid   = 1'b0;
        core_enc_in = '0;
        core_dec_in = '0;
        result      = '0;
        new_chain   = '0;
        cur_chain   = chain_q[g_q];
        cur_enc     = mode_q[g_q];
        case (state_q)
            IDLE: ch_ready = gnt;
            CALC: begin
                if (cur_enc) begin
                    core_enc_in = in_q ^ cur_chain;
                    result      = core_enc_out;
                    new_chain   = core_enc_out;
                end else begin
                    core_dec_in = in_q;
                    result      = core_dec_out ^ cur_chain;
                    new_chain   = in_q;
                end
            end
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        in_d        = in_q;
        g_d         = g_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        blk_count_d = blk_count_q;
        if (accept) begin
            in_d  = ch_data[int'(gnt_idx)*DW +: DW];
            g_d   = gnt_idx;
            ptr_d = (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + CW'(1);
        end
        if (state_q == CALC) begin
            out_data_d = result;
            out_ch_d   = g_q;
        end
        if (deliver) begin
            blk_count_d = blk_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            in_q        <= '0;
            g_q         <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            blk_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            in_q        <= in_d;
            g_q         <= g_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            blk_count_q <= blk_count_d;
        end
    end

    // A start landing in the same cycle as the chain write-back takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                chain_q[c] <= '0;
            end
            mode_q   <= '0;
            active_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_start[c]) begin
                    chain_q[c]  <= ch_iv[c*DW +: DW];
                    mode_q[c]   <= ch_mode[c];
                    active_q[c] <= 1'b1;
                end else if ((state_q == CALC) && (int'(g_q) == c)) begin
                    chain_q[c] <= new_chain;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_aes_cbc_scheduler.sv
// Self-checking bench for aes_cbc_scheduler with inverting stub cores and a CBC reference model.
module tb_aes_cbc_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   ch_start = '0;
    logic [3:0]   ch_mode = '0;
    logic [511:0] ch_iv = '0;
    logic [3:0]   ch_valid = '0;
    logic [511:0] ch_data = '0;
    logic [3:0]   ch_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic [1:0]   out_ch;
    logic         out_ready = 1'b0;
    logic [127:0] core_enc_in, core_enc_out, core_dec_in, core_dec_out;
    logic [31:0]  blk_count;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: per-channel CBC context plus round-robin pointer and delivery count.
    logic [127:0] mChain [4];
    bit           mMode [4];
    bit           mActive [4];
    int           mPtr;
    int           mBlk;

    typedef struct {
        int           ch;
        bit           isStart;
        bit           mode;
        logic [127:0] val;
        logic [127:0] expData;
    } vec_t;

    vec_t vecs [6];

    assign core_enc_out = ~core_enc_in;
    assign core_dec_out = ~core_dec_in;

    always #5 clk = ~clk;

    aes_cbc_scheduler #(.NCH(4), .DW(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_start     (ch_start),
        .ch_mode      (ch_mode),
        .ch_iv        (ch_iv),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .ch_ready     (ch_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_ready    (out_ready),
        .core_enc_in  (core_enc_in),
        .core_enc_out (core_enc_out),
        .core_dec_in  (core_dec_in),
        .core_dec_out (core_dec_out),
        .blk_count    (blk_count)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 4; c++) begin
            mChain[c]  = '0;
            mMode[c]   = 1'b0;
            mActive[c] = 1'b0;
        end
        mPtr = 0;
        mBlk = 0;
    endtask

    task automatic modelStart(input int ch, input bit m, input logic [127:0] iv);
        mChain[ch]  = iv;
        mMode[ch]   = m;
        mActive[ch] = 1'b1;
    endtask

    task automatic driveStart(input int ch, input bit m, input logic [127:0] iv);
        ch_start[ch]          = 1'b1;
        ch_mode[ch]           = m;
        ch_iv[ch*128 +: 128]  = iv;
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        ch_start  = '0;
        ch_valid  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // One arbitration slot starting in IDLE: request, optional start (in IDLE or CALC), result, handshake.
    task automatic applyStimulus(input logic [3:0] vmask, input logic [127:0] data [4],
                                 input int sCh, input bit sInCalc, input bit sMode,
                                 input logic [127:0] sIv, input int stall, input string tag,
                                 output logic [127:0] gotData, output int gotCh);
        logic [3:0]   expReady;
        logic [127:0] expData;
        bit           encMode;
        bit           idleStart;
        int           g;
        int           c;
        idleStart = (sCh >= 0) && !sInCalc;
        gotData   = '0;
        gotCh     = -1;
        @(negedge clk);
        ch_valid  = vmask;
        ch_start  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) ch_data[k*128 +: 128] = data[k];
        if (idleStart) driveStart(sCh, sMode, sIv);
        #1;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            c = (mPtr + i) % 4;
            if (g < 0 && mActive[c] && vmask[c] && !(idleStart && sCh == c)) g = c;
        end
        expReady = (g < 0) ? 4'b0000 : 4'(1 << g);
        checkOutput({tag, " ch_ready"}, ch_ready, expReady);
        if (g < 0) begin
            if (idleStart) modelStart(sCh, sMode, sIv);
            return;
        end
        encMode = mMode[g];
        if (encMode) begin
            expData   = ~(data[g] ^ mChain[g]);
            mChain[g] = expData;
        end else begin
            expData   = ~data[g] ^ mChain[g];
            mChain[g] = data[g];
        end
        mPtr = (g + 1) % 4;
        if (sCh >= 0) modelStart(sCh, sMode, sIv);
        @(negedge clk);
        ch_start = '0;
        if (sInCalc && sCh >= 0) driveStart(sCh, sMode, sIv);
        #1;
        checkOutput({tag, " calc out_valid"}, out_valid, 1'b0);
        checkOutput({tag, " idle core input"}, encMode ? core_dec_in : core_enc_in, '0);
        repeat (stall) begin
            @(negedge clk);
            ch_start = '0;
            #1;
            checkOutput({tag, " stall out_valid"}, out_valid, 1'b1);
            checkOutput({tag, " stall ch_ready"}, ch_ready, 4'b0000);
            checkOutput({tag, " stall out_data"}, out_data, expData);
            checkOutput({tag, " stall blk_count"}, blk_count, mBlk);
        end
        @(negedge clk);
        ch_start  = '0;
        out_ready = 1'b1;
        #1;
        checkOutput({tag, " out_valid"}, out_valid, 1'b1);
        checkOutput({tag, " out_data"}, out_data, expData);
        checkOutput({tag, " out_ch"}, out_ch, g);
        checkOutput({tag, " blk_count"}, blk_count, mBlk);
        gotData = out_data;
        gotCh   = int'(out_ch);
        mBlk++;
    endtask

    initial begin
        logic [127:0] data [4];
        logic [127:0] got;
        logic [127:0] ivA;
        int           gotCh;
        int           rrFull [5];
        int           rrSkip [4];

        vecs[0] = '{0, 1'b1, 1'b1, 128'h0, 128'h0};
        vecs[1] = '{0, 1'b0, 1'b0, 128'h0, {128{1'b1}}};
        vecs[2] = '{0, 1'b0, 1'b0, 128'h0, 128'h0};
        vecs[3] = '{1, 1'b1, 1'b0, 128'h1, 128'h0};
        vecs[4] = '{1, 1'b0, 1'b0, 128'h0, {{127{1'b1}}, 1'b0}};
        vecs[5] = '{1, 1'b0, 1'b0, 128'h5, ~128'h5};
        rrFull  = '{0, 1, 2, 3, 0};
        rrSkip  = '{2, 3, 0, 2};
        for (int k = 0; k < 4; k++) data[k] = '0;

        resetDut();
        #1;
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out_data", out_data, '0);
        checkOutput("reset out_ch", out_ch, '0);
        checkOutput("reset blk_count", blk_count, '0);
        checkOutput("reset core_enc_in", core_enc_in, '0);
        checkOutput("reset core_dec_in", core_dec_in, '0);
        applyStimulus(4'hF, data, -1, 1'b0, 1'b0, '0, 0, "inactive", got, gotCh);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].isStart) begin
                applyStimulus(4'h0, data, vecs[i].ch, 1'b0, vecs[i].mode, vecs[i].val, 0,
                              $sformatf("vec%0d start", i), got, gotCh);
            end else begin
                data[vecs[i].ch] = vecs[i].val;
                applyStimulus(4'(1 << vecs[i].ch), data, -1, 1'b0, 1'b0, '0, 0,
                              $sformatf("vec%0d", i), got, gotCh);
                checkOutput($sformatf("vec%0d table data", i), got, vecs[i].expData);
                checkOutput($sformatf("vec%0d table ch", i), gotCh, vecs[i].ch);
            end
        end
        @(negedge clk);
        ch_start = '0;
        #1;
        checkOutput("table blk_count", blk_count, 32'd4);

        resetDut();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'h0, data, c, 1'b0, 1'b1, rand128(), 0, "rr start", got, gotCh);
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) data[k] = rand128();
            applyStimulus(4'hF, data, -1, 1'b0, 1'b0, '0, (i == 4) ? 10 : 0,
                          $sformatf("rr%0d", i), got, gotCh);
            checkOutput($sformatf("rr%0d order", i), gotCh, rrFull[i]);
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) data[k] = rand128();
            applyStimulus(4'hD, data, -1, 1'b0, 1'b0, '0, 0,
                          $sformatf("skip%0d", i), got, gotCh);
            checkOutput($sformatf("skip%0d order", i), gotCh, rrSkip[i]);
        end

        ivA = 128'hA;
        data[2] = rand128();
        applyStimulus(4'h4, data, 2, 1'b1, 1'b1, ivA, 0, "calc start", got, gotCh);
        checkOutput("calc start ch", gotCh, 2);
        data[2] = '0;
        applyStimulus(4'h4, data, -1, 1'b0, 1'b0, '0, 0, "after start", got, gotCh);
        checkOutput("iv overrides chain", got, ~128'hA);

        for (int i = 0; i < 40; i++) begin
            int  sCh;
            for (int k = 0; k < 4; k++) data[k] = rand128();
            sCh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus(4'($urandom_range(0, 15)), data, sCh, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), rand128(), int'($urandom_range(0, 3)),
                          $sformatf("rand%0d", i), got, gotCh);
        end

        @(negedge clk);
        ch_start  = '0;
        ch_valid  = 4'hF;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset out_valid", out_valid, 1'b0);
        checkOutput("midreset ch_ready", ch_ready, 4'b0000);
        checkOutput("midreset blk_count", blk_count, '0);
        checkOutput("midreset out_data", out_data, '0);
        @(negedge clk);
        #1;
        checkOutput("midreset held out_valid", out_valid, 1'b0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
